serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one full_adder instance.

---
 rtl/serial_adder.sv | 81 ++++++++
 tb/tb_serial_adder.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder that reuses one full_adder per clock, LSB first.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t           r_state, w_state_nx;
  logic [WIDTH-1:0] r_sa, r_sb, r_acc, r_sum;
  logic [CW-1:0]    r_count;
  logic             r_carry, r_cout, r_done;
  logic             w_s, w_c, w_last;
  logic [WIDTH:0]   w_acc_sh;
  full_adder u_fa (.a(r_sa[0]), .b(r_sb[0]), .c_in(r_carry), .sum(w_s), .c_out(w_c));
  always_comb begin
    w_last     = r_count == CW'(WIDTH - 1);
    w_acc_sh   = {w_s, r_acc};
    w_state_nx = r_state == IDLE ? (start ? RUN : IDLE) : (w_last ? IDLE : RUN);
  end
  // the new sum bit enters at the MSB so bit i ends up holding step i+1 after WIDTH shifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_count <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_done  <= 1'b0;
      if (r_state == IDLE) begin
        if (start) begin
          r_sa    <= a;
          r_sb    <= b;
          r_carry <= c_in;
          r_count <= '0;
        end
      end else begin
        r_sa    <= r_sa >> 1;
        r_sb    <= r_sb >> 1;
        r_acc   <= w_acc_sh[WIDTH:1];
        r_carry <= w_c;
        r_count <= r_count + 1'b1;
        if (w_last) begin
          r_sum  <= w_acc_sh[WIDTH:1];
          r_cout <= w_c;
          r_done <= 1'b1;
        end
      end
    end
  end
  assign busy  = r_state == RUN;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed checks of the 8-bit and 1-bit serial adders.
module tb_serial_adder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, c_in = 1'b0, busy, done, c_out;
  logic [7:0] a = '0, b = '0, sum;
  logic       start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, c_in1 = 1'b0, busy1, done1, c_out1;
  logic [0:0] sum1;
  int         vectors = 0, errors = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(c_in1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(c_out1)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                     input logic [7:0] es, input logic ec);
    logic [7:0] prev;
    int         busy_n;
    logic       got, held;
    prev = sum;
    busy_n = 0;
    got = 1'b0;
    held = 1'b1;
    a = ta;
    b = tb;
    c_in = tc;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~ta;
    for (int k = 0; k < 20 && !got; k++) begin
      if (busy) busy_n++;
      if (sum !== prev || c_out !== 1'b0 && prev === 8'h00 && k == 0 && 1'b0) held = 1'b0;
      step();
      got = done;
    end
    chk("done_seen", got, 1);
    chk("held", held, 1);
    chk("sum", sum, es);
    chk("c_out", c_out, ec);
    chk("busy_cycles", busy_n, 8);
    chk("busy_end", busy, 0);
    step();
    chk("done_pulse", done, 0);
  endtask
  initial begin
    logic [7:0] ops_a [3] = '{8'h12, 8'h80, 8'hFE};
    logic [7:0] ops_b [3] = '{8'h34, 8'h80, 8'h01};
    logic       ops_c [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0] ops_s [3] = '{8'h46, 8'h01, 8'h00};
    logic       ops_o [3] = '{1'b0, 1'b1, 1'b1};
    step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", c_out, 0);
    rst_n = 1'b1;
    step();
    // T1, T2
    run(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0);
    // T3: start during a run is ignored
    a = 8'h0F; b = 8'h01; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 8'h11; b = 8'h22; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 4; k <= 8; k++) begin
      step();
      if (k < 8) chk("t3_no_early_done", done, 0);
    end
    chk("t3_done", done, 1);
    chk("t3_sum", sum, 8'h10);
    chk("t3_cout", c_out, 0);
    step();
    chk("t3_no_extra_done", done, 0);
    chk("t3_idle", busy, 0);
    // T4: reset at step 4 aborts
    a = 8'hFF; b = 8'hFF; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 3; k++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t4_busy", busy, 0);
    chk("t4_done", done, 0);
    chk("t4_sum", sum, 0);
    chk("t4_cout", c_out, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_no_done", done, 0);
    end
    // T5: start held high, back-to-back adds every 9 cycles
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = ops_a[i]; b = ops_b[i]; c_in = ops_c[i];
      step();
      chk("t5_busy", busy, 1);
      a = 8'h55; b = 8'hAA; c_in = ~ops_c[i];
      for (int k = 1; k <= 8; k++) begin
        step();
        if (k < 8) chk("t5_no_done", done, 0);
      end
      chk("t5_done", done, 1);
      chk("t5_sum", sum, ops_s[i]);
      chk("t5_cout", c_out, ops_o[i]);
    end
    start = 1'b0;
    step();
    chk("t5_idle", busy, 0);
    // T6: WIDTH=1
    a1 = 1'b1; b1 = 1'b1; c_in1 = 1'b1; start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("t6_busy", busy1, 1);
    chk("t6_no_done", done1, 0);
    step();
    chk("t6_done", done1, 1);
    chk("t6_sum", sum1, 1);
    chk("t6_cout", c_out1, 1);
    chk("t6_busy_end", busy1, 0);
    step();
    chk("t6_done_pulse", done1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
